prog_field_selector: RTL

//  Time/date programming front-end of the RTC console. Turns debounced push-button levels into
//  the field-select code en_count plus single-cycle enUP/enDOWN step pulses with auto-repeat.

---
 rtl/rtc_prog_pkg.sv | 39 +++
 rtl/prog_field_selector_if.sv | 29 ++
 rtl/autorepeat_gen.sv | 87 ++++++++
 rtl/prog_field_selector.sv | 97 +++++++++
 4 files changed

// File: rtl/rtc_prog_pkg.sv
// Shared definitions for the RTC programming console: field codes, FSM
// state encodings and cursor-step helpers used by the selector and field counters.
package rtc_prog_pkg;

   typedef enum logic [3:0] {
      FLD_NONE   = 4'd0,
      FLD_SEC    = 4'd1,
      FLD_MIN    = 4'd2,
      FLD_HOUR   = 4'd3,
      FLD_DAY    = 4'd4,
      FLD_MONTH  = 4'd5,
      FLD_YEAR   = 4'd6,
      FLD_TMR_SS = 4'd7,
      FLD_TMR_MM = 4'd8,
      FLD_TMR_HH = 4'd9
   } field_e;

   typedef enum logic {
      M_RUN  = 1'b0,
      M_EDIT = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      R_IDLE   = 2'd0,
      R_HOLD   = 2'd1,
      R_REPEAT = 2'd2,
      R_LOCK   = 2'd3
   } rep_e;

   // Cursor wraps within 1..fmax; code 0 is only used outside edit mode.
   function automatic logic [3:0] fld_next(input logic [3:0] cur, input logic [3:0] fmax);
      return (cur == fmax) ? 4'd1 : cur + 4'd1;
   endfunction

   function automatic logic [3:0] fld_prev(input logic [3:0] cur, input logic [3:0] fmax);
      return (cur == 4'd1) ? fmax : cur - 4'd1;
   endfunction

endpackage

// File: rtl/prog_field_selector_if.sv
// Console-side bundle of the field selector: button levels and mode in,
// selected field code, step pulses and FSM debug state out.
import rtc_prog_pkg::*;

interface prog_field_selector_if;
   // Handshake: no valid/ready; inputs are levels sampled every clk edge,
   // enUP/enDOWN are single-cycle strobes qualified by the en_count of the same cycle.
   logic       prog_mode;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [3:0] en_count;
   logic       enUP;
   logic       enDOWN;
   mode_e      mode_dbg;
   rep_e       rep_dbg;

   modport master (
      output prog_mode, btn_up, btn_down, btn_left, btn_right,
      input  en_count, enUP, enDOWN, mode_dbg, rep_dbg
   );

   modport slave (
      input  prog_mode, btn_up, btn_down, btn_left, btn_right,
      output en_count, enUP, enDOWN, mode_dbg, rep_dbg
   );

endinterface

// File: rtl/autorepeat_gen.sv
// Step/auto-repeat FSM: first press gives one pulse, a long hold gives a
// periodic train; pressing both buttons locks out stepping until both are released.
import rtc_prog_pkg::*;

module autorepeat_gen #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic up,
   input  logic down,
   input  logic up_rise,
   input  logic dn_rise,
   input  logic clear,
   output logic up_pulse,
   output logic dn_pulse,
   output rep_e state_dbg
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   rep_e             state;
   logic             dir_up;
   logic [CNT_W-1:0] timer;
   logic             active;

   assign active    = dir_up ? up : down;
   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= R_IDLE;
         dir_up   <= 1'b0;
         timer    <= '0;
         up_pulse <= 1'b0;
         dn_pulse <= 1'b0;
      end else begin
         up_pulse <= 1'b0;
         dn_pulse <= 1'b0;
         if (clear) begin
            state <= R_IDLE;
            timer <= '0;
         end else if (up && down) begin
            state <= R_LOCK;
            timer <= '0;
         end else begin
            case (state)
               R_IDLE: begin
                  if (up_rise) begin
                     up_pulse <= 1'b1;
                     dir_up   <= 1'b1;
                     timer    <= '0;
                     state    <= R_HOLD;
                  end else if (dn_rise) begin
                     dn_pulse <= 1'b1;
                     dir_up   <= 1'b0;
                     timer    <= '0;
                     state    <= R_HOLD;
                  end
               end
               R_HOLD, R_REPEAT: begin
                  if (!active) begin
                     state <= R_IDLE;
                     timer <= '0;
                  end else if (timer == ((state == R_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                     up_pulse <= dir_up;
                     dn_pulse <= !dir_up;
                     timer    <= '0;
                     state    <= R_REPEAT;
                  end else if (timer != '1) begin
                     timer <= timer + 1'b1;
                  end
               end
               R_LOCK: begin
                  // Only a full release re-arms stepping, so a leftover held button cannot restart.
                  if (!up && !down) state <= R_IDLE;
               end
               default: state <= R_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/prog_field_selector.sv
// Programming front-end: edge-detects buttons, runs the RUN/EDIT mode FSM and
// field cursor, and forwards step pulses from the auto-repeat generator.
import rtc_prog_pkg::*;

module prog_field_selector #(
   parameter int FIELD_MAX     = 9,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 26
) (
   input logic                  clk,
   input logic                  reset,
   prog_field_selector_if.slave bus
);

   localparam logic [3:0] FMAX = 4'(FIELD_MAX);

   logic       up_q, dn_q, lf_q, rt_q;
   logic       up_rise, dn_rise, lf_rise, rt_rise;
   logic       edit_now, move, clear;
   logic       up_pulse, dn_pulse;
   mode_e      mode;
   logic [3:0] en_count;
   rep_e       rep_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {up_q, dn_q, lf_q, rt_q} <= 4'b0000;
      end else begin
         {up_q, dn_q, lf_q, rt_q} <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
      end
   end

   assign up_rise  = bus.btn_up    && !up_q;
   assign dn_rise  = bus.btn_down  && !dn_q;
   assign lf_rise  = bus.btn_left  && !lf_q;
   assign rt_rise  = bus.btn_right && !rt_q;

   // Simultaneous left+right rises cancel out and are not a cursor move.
   assign edit_now = (mode == M_EDIT) && bus.prog_mode;
   assign move     = edit_now && (lf_rise != rt_rise);
   assign clear    = !edit_now || move;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode     <= M_RUN;
         en_count <= FLD_NONE;
      end else begin
         case (mode)
            M_RUN: begin
               if (bus.prog_mode) begin
                  mode     <= M_EDIT;
                  en_count <= FLD_SEC;
               end else begin
                  en_count <= FLD_NONE;
               end
            end
            M_EDIT: begin
               if (!bus.prog_mode) begin
                  mode     <= M_RUN;
                  en_count <= FLD_NONE;
               end else if (move) begin
                  en_count <= rt_rise ? fld_next(en_count, FMAX) : fld_prev(en_count, FMAX);
               end
            end
            default: begin
               mode     <= M_RUN;
               en_count <= FLD_NONE;
            end
         endcase
      end
   end

   autorepeat_gen #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
   ) u_autorepeat (
      .clk      (clk),
      .reset    (reset),
      .up       (bus.btn_up),
      .down     (bus.btn_down),
      .up_rise  (up_rise),
      .dn_rise  (dn_rise),
      .clear    (clear),
      .up_pulse (up_pulse),
      .dn_pulse (dn_pulse),
      .state_dbg(rep_state)
   );

   assign bus.en_count = en_count;
   assign bus.enUP     = up_pulse;
   assign bus.enDOWN   = dn_pulse;
   assign bus.mode_dbg = mode;
   assign bus.rep_dbg  = rep_state;

endmodule
